// File: rtl/tcdm_streamer_pkg.sv
// tcdm_streamer_pkg: shared types and helpers for the TCDM read streamer.
// Rev 1.0
`default_nettype none

package tcdm_streamer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StDrain = 2'd2
   } state_e;

   localparam logic [3:0] AmoNone = 4'h0;

   // Width needed to hold a count in the range 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/tcdm_rsp_fifo.sv
// tcdm_rsp_fifo: registered response buffer with occupancy count; any depth >= 2.
// Rev 1.0
`default_nettype none

module tcdm_rsp_fifo
   import tcdm_streamer_pkg::*;
#(
   parameter int Width = 64,
   parameter int Depth = 4,
   parameter int CntW  = cnt_width(Depth)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] rdata,
   output logic             empty,
   output logic [CntW-1:0]  count
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CntW'(Depth));
   assign do_pop  = pop && !empty;
   // A full buffer still accepts a write when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/tcdm_read_streamer.sv
// tcdm_read_streamer: credit-based strided TCDM reader producing a valid/ready stream.
// Rev 1.0
`default_nettype none

module tcdm_read_streamer
   import tcdm_streamer_pkg::*;
#(
   parameter int DataWidth = 64,
   parameter int AddrWidth = 17,
   parameter int LenWidth  = 16,
   parameter int FifoDepth = 4,
   parameter int CoreId    = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [AddrWidth-1:0]   cfg_base_addr_i,
   input  logic [AddrWidth-1:0]   cfg_stride_i,
   input  logic [LenWidth-1:0]    cfg_len_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   tcdm_req_write_o,
   output logic [AddrWidth-1:0]   tcdm_req_addr_o,
   output logic [3:0]             tcdm_req_amo_o,
   output logic [DataWidth-1:0]   tcdm_req_data_o,
   output logic [DataWidth/8-1:0] tcdm_req_strb_o,
   output logic [4:0]             tcdm_req_user_core_id_o,
   output logic                   tcdm_req_user_is_core_o,
   output logic                   tcdm_req_q_valid_o,
   input  logic                   tcdm_rsp_q_ready_i,
   input  logic                   tcdm_rsp_p_valid_i,
   input  logic [DataWidth-1:0]   tcdm_rsp_data_i,
   output logic [DataWidth-1:0]   stream_data_o,
   output logic                   stream_valid_o,
   input  logic                   stream_ready_i
);

   localparam int CntW = cnt_width(FifoDepth);

   state_e               state;
   state_e               state_next;
   logic [AddrWidth-1:0] addr;
   logic [AddrWidth-1:0] stride;
   logic [LenWidth-1:0]  len;
   logic [LenWidth-1:0]  issued;
   logic [LenWidth-1:0]  popped;
   logic [CntW-1:0]      outstanding;
   logic [CntW-1:0]      fifo_count;
   logic [CntW:0]        reserved;
   logic                 fifo_empty;
   logic                 has_credit;
   logic                 req_hs;
   logic                 rsp_push;
   logic                 pop;
   logic                 last_issue;
   logic                 drain_done;
   logic                 finish;
   logic                 start_ok;

   assign tcdm_req_write_o        = 1'b0;
   assign tcdm_req_amo_o          = AmoNone;
   assign tcdm_req_data_o         = '0;
   assign tcdm_req_strb_o         = '1;
   assign tcdm_req_user_core_id_o = 5'(CoreId);
   assign tcdm_req_user_is_core_o = 1'b0;
   assign tcdm_req_addr_o         = addr;

   // Credits only shrink through our own handshakes, so a raised valid never drops.
   assign reserved   = {1'b0, fifo_count} + {1'b0, outstanding};
   assign has_credit = reserved < (CntW + 1)'(FifoDepth);

   assign start_ok   = (state == StIdle) && start_i;
   assign req_hs     = tcdm_req_q_valid_o && tcdm_rsp_q_ready_i;
   assign rsp_push   = tcdm_rsp_p_valid_i && (outstanding != '0);
   assign pop        = stream_valid_o && stream_ready_i;
   assign last_issue = req_hs && ((issued + LenWidth'(1)) == len);
   assign drain_done = (outstanding == '0) && fifo_empty && (popped == len);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= StIdle;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         StIdle:  if (start_i) state_next = (cfg_len_i == '0) ? StDrain : StIssue;
         StIssue: if (last_issue) state_next = StDrain;
         StDrain: if (drain_done) state_next = StIdle;
         default: state_next = StIdle;
      endcase
   end

   always_comb begin
      tcdm_req_q_valid_o = (state == StIssue) && has_credit;
      busy_o             = (state != StIdle);
      finish             = (state == StDrain) && drain_done;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr        <= '0;
         stride      <= '0;
         len         <= '0;
         issued      <= '0;
         popped      <= '0;
         outstanding <= '0;
         done_o      <= 1'b0;
      end else begin
         done_o <= finish;
         if (start_ok) begin
            addr   <= cfg_base_addr_i;
            stride <= cfg_stride_i;
            len    <= cfg_len_i;
            issued <= '0;
            popped <= '0;
         end else begin
            if (req_hs) begin
               addr   <= addr + stride;
               issued <= issued + LenWidth'(1);
            end
            if (pop) popped <= popped + LenWidth'(1);
         end
         case ({req_hs, rsp_push})
            2'b10:   outstanding <= outstanding + CntW'(1);
            2'b01:   outstanding <= outstanding - CntW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   tcdm_rsp_fifo #(
      .Width (DataWidth),
      .Depth (FifoDepth),
      .CntW  (CntW)
   ) u_rsp_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (rsp_push),
      .wdata (tcdm_rsp_data_i),
      .pop   (pop),
      .rdata (stream_data_o),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign stream_valid_o = !fifo_empty;

   a_no_stray_rsp : assert property (@(posedge clk_i) disable iff (rst_i)
      tcdm_rsp_p_valid_i |-> (outstanding != '0))
      else $error("response received with no request outstanding");

endmodule

`default_nettype wire

// File: tb/tb_tcdm_read_streamer.sv
// tb_tcdm_read_streamer: directed bench with a 1-cycle-latency memory that returns addr as data.
// Rev 1.0
`default_nettype none

module tb_tcdm_read_streamer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [16:0] base = '0;
   logic [16:0] stride = '0;
   logic [15:0] len = '0;
   logic        busy, done;
   logic        req_write;
   logic [16:0] req_addr;
   logic [3:0]  req_amo;
   logic [63:0] req_data;
   logic [7:0]  req_strb;
   logic [4:0]  core_id;
   logic        is_core;
   logic        q_valid;
   logic        q_ready = 1'b1;
   logic        p_valid = 1'b0;
   logic [63:0] p_data = '0;
   logic [63:0] s_data;
   logic        s_valid;
   logic        s_ready = 1'b1;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0, first_req = -1, last_req = -1;
   int qv_cnt = 0, done_cnt = 0, busy_cnt = 0;
   logic        pend = 1'b0;
   logic [16:0] pend_addr = '0;
   logic [16:0] req_q[$];
   logic [63:0] got_q[$];

   always #5 clk = ~clk;

   tcdm_read_streamer dut (
      .clk_i                   (clk),
      .rst_i                   (rst),
      .start_i                 (start),
      .cfg_base_addr_i         (base),
      .cfg_stride_i            (stride),
      .cfg_len_i               (len),
      .busy_o                  (busy),
      .done_o                  (done),
      .tcdm_req_write_o        (req_write),
      .tcdm_req_addr_o         (req_addr),
      .tcdm_req_amo_o          (req_amo),
      .tcdm_req_data_o         (req_data),
      .tcdm_req_strb_o         (req_strb),
      .tcdm_req_user_core_id_o (core_id),
      .tcdm_req_user_is_core_o (is_core),
      .tcdm_req_q_valid_o      (q_valid),
      .tcdm_rsp_q_ready_i      (q_ready),
      .tcdm_rsp_p_valid_i      (p_valid),
      .tcdm_rsp_data_i         (p_data),
      .stream_data_o           (s_data),
      .stream_valid_o          (s_valid),
      .stream_ready_i          (s_ready)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Observe at the falling edge, then drive the memory response after the rising edge.
   task automatic cycle();
      @(negedge clk);
      pend = 1'b0;
      if (q_valid && q_ready) begin
         req_q.push_back(req_addr);
         pend      = 1'b1;
         pend_addr = req_addr;
         if (first_req < 0) first_req = cyc;
         last_req = cyc;
      end
      if (q_valid) qv_cnt++;
      if (s_valid && s_ready) got_q.push_back(s_data);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      cyc++;
      p_valid = pend && !rst;
      p_data  = {47'b0, pend_addr};
   endtask

   task automatic start_run(input logic [16:0] b, input logic [16:0] s, input logic [15:0] l);
      req_q.delete();
      got_q.delete();
      first_req = -1;
      last_req  = -1;
      qv_cnt    = 0;
      done_cnt  = 0;
      busy_cnt  = 0;
      base   = b;
      stride = s;
      len    = l;
      start  = 1'b1;
      cycle();
      start  = 1'b0;
   endtask

   task automatic run_to_done(input int budget, input string tag);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < budget) begin
         cycle();
         n++;
      end
      check({tag, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
   endtask

   task automatic check_seq(input string tag, input logic [16:0] b, input logic [16:0] s,
                            input int l);
      logic [16:0] a = b;
      check({tag, "_nreq"}, 64'(req_q.size()), 64'(l));
      check({tag, "_nelem"}, 64'(got_q.size()), 64'(l));
      for (int i = 0; i < l; i++) begin
         if (i < req_q.size()) check($sformatf("%s_req%0d", tag, i), 64'(req_q[i]), 64'(a));
         if (i < got_q.size()) check($sformatf("%s_elem%0d", tag, i), got_q[i], 64'(a));
         a = a + s;
      end
   endtask

   initial begin
      repeat (3) cycle();
      rst = 1'b0;
      cycle();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_qvalid", 64'(q_valid), 64'd0);
      check("rst_svalid", 64'(s_valid), 64'd0);
      check("rst_addr", 64'(req_addr), 64'd0);
      check("const_fields", {req_data[31:0], 8'(req_amo), req_strb, 8'(core_id),
                             6'd0, is_core, req_write}, {32'd0, 8'h00, 8'hFF, 8'h00, 8'h00});

      // Basic read, ready everywhere.
      start_run(17'h100, 17'd8, 16'd4);
      run_to_done(60, "basic");
      repeat (3) cycle();
      check_seq("basic", 17'h100, 17'd8, 4);
      check("basic_qv_cycles", 64'(qv_cnt), 64'd4);
      check("basic_b2b_span", 64'(last_req - first_req), 64'd3);
      check("basic_done_once", 64'(done_cnt), 64'd1);

      // Zero length: no requests, busy one cycle, done the cycle after.
      start_run(17'h300, 17'd8, 16'd0);
      check("zl_busy_c1", 64'(busy), 64'd1);
      check("zl_done_c1", 64'(done), 64'd0);
      cycle();
      check("zl_done_c2", 64'(done), 64'd1);
      check("zl_busy_c2", 64'(busy), 64'd0);
      repeat (3) cycle();
      check("zl_qv_never", 64'(qv_cnt), 64'd0);
      check("zl_busy_cycles", 64'(busy_cnt), 64'd1);
      check("zl_done_once", 64'(done_cnt), 64'd1);

      // Back-pressure fills the buffer; only FifoDepth requests may go out.
      s_ready = 1'b0;
      start_run(17'h200, 17'd8, 16'd10);
      repeat (20) cycle();
      check("bp_nreq_stalled", 64'(req_q.size()), 64'd4);
      check("bp_qvalid_low", 64'(q_valid), 64'd0);
      check("bp_svalid", 64'(s_valid), 64'd1);
      s_ready = 1'b1;
      run_to_done(100, "bp");
      check_seq("bp", 17'h200, 17'd8, 10);

      // Request stall on the second request.
      start_run(17'h100, 17'd8, 16'd4);
      for (int n = 0; n < 10 && req_q.size() < 1; n++) cycle();
      q_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("stall_addr%0d", k), 64'(req_addr), 64'h108);
         check($sformatf("stall_qv%0d", k), 64'(q_valid), 64'd1);
         cycle();
      end
      check("stall_nreq_held", 64'(req_q.size()), 64'd1);
      q_ready = 1'b1;
      run_to_done(60, "stall");
      check_seq("stall", 17'h100, 17'd8, 4);

      // Address wrap at the top of the 17-bit space.
      start_run(17'h1FFF8, 17'd8, 16'd3);
      run_to_done(60, "wrap");
      check_seq("wrap", 17'h1FFF8, 17'd8, 3);

      // Reset mid-run with a response still in flight.
      start_run(17'h000, 17'h10, 16'd8);
      for (int n = 0; n < 20 && req_q.size() < 2; n++) cycle();
      check("mr_pending_rsp", 64'(p_valid), 64'd1);
      rst = 1'b1;
      #1;
      check("mr_qvalid", 64'(q_valid), 64'd0);
      check("mr_svalid", 64'(s_valid), 64'd0);
      check("mr_busy", 64'(busy), 64'd0);
      check("mr_addr", 64'(req_addr), 64'd0);
      cycle();
      rst = 1'b0;
      repeat (2) cycle();
      check("mr_dropped_svalid", 64'(s_valid), 64'd0);
      check("mr_idle_busy", 64'(busy), 64'd0);
      start_run(17'h40, 17'd4, 16'd2);
      run_to_done(40, "mr");
      repeat (2) cycle();
      check_seq("mr", 17'h40, 17'd4, 2);
      check("mr_done_once", 64'(done_cnt), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
